instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Reader side of the program ROM: owns the program counter, drives the ROM address, and registers the returned 4-bit instruction into a one-entry output buffer. Presents instructions to the decode/execute stage over a valid/ready handshake, one per cycle at full throughput. Supports skip-next for SNZ A/SNZ S, end-of-program halt or wrap, and a run enable. Sits between the combinational ProgramROM family and the CPU decoder.

Parameters:
ADDR_W, 4, ROM address / PC width.
INSTR_W, 4, instruction width.
LAST_ADDR, 15, highest program address fetched before end-of-program handling.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  run enable; low freezes fetching.
loop_en  in  1  1: wrap PC to 0 after LAST_ADDR; 0: halt after LAST_ADDR.
rom_addr  out  ADDR_W  address to ROM (= pc, combinational from pc register).
rom_data  in  INSTR_W  ROM instruction, combinational from rom_addr.
instr_out  out  INSTR_W  buffered instruction.
instr_valid  out  1  instr_out holds an instruction.
instr_ready  in  1  decoder accepts; transfer = valid & ready at rising edge.
instr_addr  out  ADDR_W  ROM address instr_out was fetched from.
skip_req  in  1  one-cycle pulse from execute: SNZ condition true, drop next instruction.
halted  out  1  program ended, buffer empty.

Behaviour:
- Reset (rst=1 at edge, priority over all inputs): pc=0, state=IDLE, instr_valid=0, instr_out=4'b0111 (CLR/NOP), instr_addr=0, halted=0, skip_pending=0, end_seen=0.
- States: IDLE, RUN, DRAIN, HALT.
- IDLE: instr_valid=0. enable=1 -> RUN (no fetch this cycle).
- RUN, "load" occurs at an edge when enable=1, end_seen=0, and buffer is empty or transferring: instr_out<=rom_data, instr_addr<=pc, instr_valid<=1, pc<=pc+1.
  - Latency: first valid instruction is 2 cycles after enable rises (IDLE->RUN, then load). Steady state: 1 instruction/cycle with ready held high.
  - Buffer full and ready=0: hold instr_out/instr_addr/pc; valid stays 1.
  - enable=0: no load; a buffered instruction may still transfer; valid drops after transfer.
- End of program: load from pc==LAST_ADDR: if loop_en=1, pc<=0 and continue; else set end_seen=1, state->DRAIN. DRAIN: no loads; when the buffer empties -> HALT. HALT: halted=1, instr_valid=0, instr_out=4'b0111; exit only via rst.
- Skip: skip_req is asserted the cycle after the decoder accepts SNZ A (1000) or SNZ S (1001).
  - Buffer valid: buffered instruction is discarded (never counts as transferred, even if instr_ready=1 in the same cycle; the decoder ignores that cycle's transfer). If load conditions hold, the next instruction loads the same edge.
  - Buffer empty (enable=0, or DRAIN): set skip_pending. The next load goes through the PC but does not set valid. skip_pending clears.
  - Buffer empty in HALT/DRAIN with nothing left to fetch: skip is dropped.
- Simultaneous skip_req and end-of-program load: the load from LAST_ADDR is discarded. With loop_en=0 the block enters DRAIN with an empty buffer and reaches HALT next cycle.
- PC arithmetic: unsigned ADDR_W; increment modulo 2^ADDR_W. Wrap to 0 is explicit when LAST_ADDR < 2^ADDR_W-1.
- Reset mid-operation: the buffered instruction is lost and fetch restarts at address 0 after enable.

Decomposition:
- Shared package (cpu_pkg): ADDR_W/INSTR_W constants; opcode constants OP_LDA=0000, OP_LDB=0001, OP_LDO=0010, OP_LDSA=0011, OP_LDSB=0100, OP_LSH=0101, OP_RSH=0110, OP_CLR=0111, OP_SNZA=1000, OP_SNZS=1001, OP_ADD=1010, OP_SUB=1011, OP_XOR=1110; fetch state enum.
- One sub-module: program_counter (pc register, increment, wrap/end detect against LAST_ADDR, loop_en), instantiated by instr_fetch_unit.

Test Plan:
- Reset, enable=1, ready=1, loop_en=0, main ROM -> first valid at cycle 2 after enable: 0000,0001,1010,0010,1011,0010,1110,0010,0011,0110,1000,0010,0010,0100,0010,0111 with instr_addr 0..15. halted=1 on the cycle after addr 15 transfers.
- ready low for 3 cycles while addr 2 (1010) is buffered -> instr_out/instr_addr stable at 1010/2, pc=3 held. Resumes with 0010 at addr 3 the cycle after ready rises.
- skip_req pulse after SNZ A at addr 10 is accepted -> addr 11 (0010) never transferred; next transfer is addr 12 (0010), then addr 13 (0100).
- loop_en=1 -> after addr 15 (0111) the next transfer is addr 0 (0000), halted stays 0.
- enable dropped for 4 cycles mid-program -> buffered instruction drains, valid=0, pc frozen. skip_req during the gap -> first instruction after re-enable is discarded.
- rst asserted while addr 6 is buffered -> next cycle valid=0, instr_out=0111, pc=0. Re-enable restarts at addr 0 (0000).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode map and fetch states.
// Imported by the fetch unit, its program counter and the fetch interface.
package cpu_pkg;

    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 4;

    localparam logic [INSTR_W-1:0] OP_LDA  = 4'b0000;
    localparam logic [INSTR_W-1:0] OP_LDB  = 4'b0001;
    localparam logic [INSTR_W-1:0] OP_LDO  = 4'b0010;
    localparam logic [INSTR_W-1:0] OP_LDSA = 4'b0011;
    localparam logic [INSTR_W-1:0] OP_LDSB = 4'b0100;
    localparam logic [INSTR_W-1:0] OP_LSH  = 4'b0101;
    localparam logic [INSTR_W-1:0] OP_RSH  = 4'b0110;
    localparam logic [INSTR_W-1:0] OP_CLR  = 4'b0111;
    localparam logic [INSTR_W-1:0] OP_SNZA = 4'b1000;
    localparam logic [INSTR_W-1:0] OP_SNZS = 4'b1001;
    localparam logic [INSTR_W-1:0] OP_ADD  = 4'b1010;
    localparam logic [INSTR_W-1:0] OP_SUB  = 4'b1011;
    localparam logic [INSTR_W-1:0] OP_XOR  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
// master (fetch): drives instr_out/instr_valid/instr_addr; slave (decode): drives instr_ready/skip_req.
interface instr_fetch_unit_if ();
    import cpu_pkg::*;

    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic [ADDR_W-1:0]  instr_addr;
    logic               instr_ready;
    logic               skip_req;

    modport master (
        output instr_out,
        output instr_valid,
        output instr_addr,
        input  instr_ready,
        input  skip_req
    );

    modport slave (
        input  instr_out,
        input  instr_valid,
        input  instr_addr,
        output instr_ready,
        output skip_req
    );

endinterface

// File: rtl/program_counter.sv
// Program counter with end-of-program detect and optional wrap to 0.
// Ports: clk, rst, i_adv (advance), i_loop_en, o_pc, o_at_last (pc == LAST_ADDR).
module program_counter
    import cpu_pkg::*;
#(
    parameter int LAST_ADDR = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    input  logic              i_loop_en,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_at_last
);

    logic [ADDR_W-1:0] r_pc;
    logic              w_at_last;

    assign w_at_last = (r_pc == ADDR_W'(LAST_ADDR));
    assign o_at_last = w_at_last;
    assign o_pc      = r_pc;

    // Without loop_en the pc parks on LAST_ADDR once the program ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_adv) begin
            if (!w_at_last) begin
                r_pc <= r_pc + ADDR_W'(1);
            end else if (i_loop_en) begin
                r_pc <= '0;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: drives ROM address from the pc, buffers one instruction for decode.
// Ports: clk, rst, enable, loop_en, rom_addr/rom_data (ROM), halted, bus (fetch handshake).
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int LAST_ADDR = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               loop_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               halted,
    instr_fetch_unit_if.master bus
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [INSTR_W-1:0] r_instr_out;
    logic [ADDR_W-1:0]  r_instr_addr;
    logic               r_valid;
    logic               r_skip_pending;
    logic               r_end_seen;

    logic [ADDR_W-1:0]  w_pc;
    logic               w_at_last;
    logic               w_buf_free;
    logic               w_load;
    logic               w_drop;
    logic               w_end;

    program_counter #(
        .LAST_ADDR (LAST_ADDR)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .i_adv     (w_load),
        .i_loop_en (loop_en),
        .o_pc      (w_pc),
        .o_at_last (w_at_last)
    );

    assign rom_addr = w_pc;

    // A skip frees the buffer just like a transfer does.
    assign w_buf_free = !r_valid || bus.instr_ready || bus.skip_req;
    assign w_load     = (r_state == ST_RUN) && enable
                        && !r_end_seen && w_buf_free;
    // A load is swallowed by a pending skip, by a skip arriving on an
    // empty buffer, or by a skip coinciding with the last-address load.
    assign w_drop     = r_skip_pending
                        || (bus.skip_req && (!r_valid || w_at_last));
    assign w_end      = w_load && w_at_last && !loop_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (enable)     w_state_nxt = ST_RUN;
            ST_RUN:   if (w_end)      w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_buf_free) w_state_nxt = ST_HALT;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_out   = r_instr_out;
        bus.instr_valid = r_valid;
        bus.instr_addr  = r_instr_addr;
        halted          = (r_state == ST_HALT);
        if (r_state == ST_HALT) begin
            bus.instr_out = OP_CLR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_out    <= OP_CLR;
            r_instr_addr   <= '0;
            r_valid        <= 1'b0;
            r_skip_pending <= 1'b0;
            r_end_seen     <= 1'b0;
        end else begin
            if (w_load) begin
                r_instr_out    <= rom_data;
                r_instr_addr   <= w_pc;
                r_valid        <= !w_drop;
                r_skip_pending <= 1'b0;
            end else begin
                if (r_valid && (bus.instr_ready || bus.skip_req)) begin
                    r_valid <= 1'b0;
                end
                // Skip on an empty buffer while fetching is paused: remember it.
                if (bus.skip_req && !r_valid && (r_state == ST_RUN)) begin
                    r_skip_pending <= 1'b1;
                end
            end
            if (w_end) begin
                r_end_seen <= 1'b1;
            end
        end
    end

endmodule
